// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character-LCD text engine.
//   - HD44780 command constants used during init, refresh and display control
//   - DDRAM row base address table and a helper to build the set-address command
//   - State enums for the sequencing FSM and the bus-write phase FSM
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR           = 8'h01;
    localparam logic [7:0] CMD_ENTRY           = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DISP_ON         = 8'h0C;  // display on, C/B in bits 1/0
    localparam logic [7:0] CMD_FUNC_8BIT_1LINE = 8'h30;
    localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] CMD_SET_DDRAM       = 8'h80;

    // DDRAM start address of rows 0..3 (entry i holds row i)
    localparam logic [3:0][6:0] ROW_BASE = {7'h54, 7'h14, 7'h40, 7'h00};

    function automatic logic [7:0] row_addr_cmd(input logic [1:0] row);
        return CMD_SET_DDRAM | {1'b0, ROW_BASE[row]};
    endfunction

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ROWADDR,
        ST_DATA,
        ST_CTRL
    } lcd_state_e;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        WR_WAIT
    } wr_phase_e;

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: performs one LCD bus write as SETUP / STROBE / HOLD phases of
// STEP_CYC cycles each, optionally followed by WAIT_CYC idle cycles.
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   start           load cmd_rs/cmd_data/extra_wait and begin a write
//   cmd_rs          register select for this write (0 command, 1 data)
//   cmd_data        byte for this write
//   extra_wait      append WAIT_CYC cycles after HOLD
//   done            high in the final cycle of the write; start may be
//                   asserted in that same cycle for back-to-back writes
//   lcd_en          E strobe, high only during STROBE
//   lcd_rs, lcd_d   held stable from SETUP through HOLD
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned STEP_CYC = 800,
    parameter int unsigned WAIT_CYC = 80000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    input  logic       extra_wait,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_d
);

    localparam int unsigned CNT_MAX = (STEP_CYC > WAIT_CYC) ? STEP_CYC : WAIT_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);
    localparam bit            HAS_WAIT  = (WAIT_CYC != 0);

    wr_phase_e     phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          extra_q;
    logic          step_last;

    assign step_last = (cnt_q == STEP_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= WR_IDLE;
            cnt_q   <= '0;
            extra_q <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_d   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (start) begin
                extra_q <= extra_wait;
                lcd_rs  <= cmd_rs;
                lcd_d   <= cmd_data;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        unique case (phase_q)
            WR_IDLE: cnt_d = '0;
            WR_SETUP: begin
                if (step_last) begin
                    phase_d = WR_STROBE;
                    cnt_d   = '0;
                end
            end
            WR_STROBE: begin
                if (step_last) begin
                    phase_d = WR_HOLD;
                    cnt_d   = '0;
                end
            end
            WR_HOLD: begin
                if (step_last) begin
                    phase_d = (extra_q && HAS_WAIT) ? WR_WAIT : WR_IDLE;
                    cnt_d   = '0;
                end
            end
            WR_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    phase_d = WR_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = WR_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (start) begin
            phase_d = WR_SETUP;
            cnt_d   = '0;
        end
    end

    // E decoded from the phase register so reset removes it immediately
    always_comb begin
        lcd_en = (phase_q == WR_STROBE);
        done   = ((phase_q == WR_HOLD) && step_last && !(extra_q && HAS_WAIT))
              || ((phase_q == WR_WAIT) && (cnt_q == WAIT_LAST));
    end

endmodule

// File: rtl/lcd_text_engine.sv
// lcd_text_engine: ROWS x COLS HD44780-class character LCD driver.
// After reset it waits PWRUP_CYC cycles, runs the init command sequence, then
// accepts frames over a valid/ready handshake and writes them row by row.
// Cursor/blink changes seen while idle are written as a display-control command.
// Ports:
//   clock, reset_n       system clock, asynchronous active-low reset
//   msg_in               frame, char i at msg_in[8*i+:8] (row i/COLS, col i%COLS)
//   msg_valid/msg_ready  frame handshake; ready only while idle
//   cursor_on, blink_on  display-control C and B bits
//   busy                 high whenever the engine is not idle
//   lcd_en/rs/rw/d       LCD pins (rw tied low, write-only)
module lcd_text_engine
    import lcd_pkg::*;
#(
    parameter int unsigned ROWS         = 2,
    parameter int unsigned COLS         = 16,
    parameter int unsigned STEP_CYC     = 800,
    parameter int unsigned CLEAR_CYC    = 80000,
    parameter int unsigned PWRUP_CYC    = 800000,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ROWS*COLS*8-1:0] msg_in,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic                   cursor_on,
    input  logic                   blink_on,
    output logic                   busy,
    output logic                   lcd_en,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic [7:0]             lcd_d
);

    localparam int unsigned NCHAR = ROWS * COLS;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned IW    = $clog2(NCHAR);
    localparam int unsigned PW    = $clog2(PWRUP_CYC + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);
    localparam logic [7:0]    FUNC_CMD = (ROWS > 1) ? CMD_FUNC_8BIT_2LINE : CMD_FUNC_8BIT_1LINE;

    lcd_state_e              state_q, state_d;
    logic [PW-1:0]           pwr_q, pwr_d;
    logic [1:0]              init_q, init_d;
    logic [RW-1:0]           row_q, row_d, row_nxt;
    logic [CW-1:0]           col_q, col_d;
    logic [NCHAR-1:0][7:0]   frame_q;
    logic                    frame_load;
    logic                    disp_c_q, disp_b_q, disp_load;
    logic [7:0]              disp_cmd;
    logic [IW-1:0]           row_first, char_next;

    logic                    wr_start, wr_rs, wr_extra, wr_done;
    logic [7:0]              wr_d;

    assign lcd_rw    = 1'b0;
    assign row_nxt   = row_q + RW'(1);
    assign row_first = IW'(row_q) * IW'(COLS);
    assign char_next = row_first + IW'(col_q) + IW'(1);
    assign disp_cmd  = CMD_DISP_ON | {6'b0, cursor_on, blink_on};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_PWRUP;
            pwr_q    <= '0;
            init_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            frame_q  <= {NCHAR{8'h20}};
            disp_c_q <= 1'b0;
            disp_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            init_q  <= init_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (frame_load) frame_q <= msg_in;
            if (disp_load) begin
                disp_c_q <= cursor_on;
                disp_b_q <= blink_on;
            end
        end
    end

    // Each transition into a bus-writing step issues the writer start in the
    // same cycle, so consecutive writes follow each other without gaps.
    always_comb begin
        state_d    = state_q;
        pwr_d      = pwr_q;
        init_d     = init_q;
        row_d      = row_q;
        col_d      = col_q;
        frame_load = 1'b0;
        disp_load  = 1'b0;
        wr_start   = 1'b0;
        wr_rs      = 1'b0;
        wr_d       = '0;
        wr_extra   = 1'b0;
        unique case (state_q)
            ST_PWRUP: begin
                if (pwr_q == PWR_LAST) begin
                    state_d  = ST_INIT;
                    pwr_d    = '0;
                    init_d   = 2'd0;
                    wr_start = 1'b1;
                    wr_d     = FUNC_CMD;
                end else begin
                    pwr_d = pwr_q + PW'(1);
                end
            end
            ST_INIT: begin
                if (wr_done) begin
                    unique case (init_q)
                        2'd0: begin
                            init_d    = 2'd1;
                            wr_start  = 1'b1;
                            wr_d      = disp_cmd;
                            disp_load = 1'b1;
                        end
                        2'd1: begin
                            init_d   = 2'd2;
                            wr_start = 1'b1;
                            wr_d     = CMD_CLEAR;
                            wr_extra = 1'b1;
                        end
                        2'd2: begin
                            init_d   = 2'd3;
                            wr_start = 1'b1;
                            wr_d     = CMD_ENTRY;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_IDLE: begin
                if (msg_valid) begin
                    frame_load = 1'b1;
                    state_d    = ST_ROWADDR;
                    row_d      = '0;
                    wr_start   = 1'b1;
                    wr_d       = row_addr_cmd(2'd0);
                end else if ({cursor_on, blink_on} != {disp_c_q, disp_b_q}) begin
                    state_d   = ST_CTRL;
                    wr_start  = 1'b1;
                    wr_d      = disp_cmd;
                    disp_load = 1'b1;
                end else if (AUTO_REFRESH) begin
                    state_d  = ST_ROWADDR;
                    row_d    = '0;
                    wr_start = 1'b1;
                    wr_d     = row_addr_cmd(2'd0);
                end
            end
            ST_ROWADDR: begin
                if (wr_done) begin
                    state_d  = ST_DATA;
                    col_d    = '0;
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_d     = frame_q[row_first];
                end
            end
            ST_DATA: begin
                if (wr_done) begin
                    if (col_q != COL_LAST) begin
                        col_d    = col_q + CW'(1);
                        wr_start = 1'b1;
                        wr_rs    = 1'b1;
                        wr_d     = frame_q[char_next];
                    end else if (row_q != ROW_LAST) begin
                        state_d  = ST_ROWADDR;
                        row_d    = row_nxt;
                        wr_start = 1'b1;
                        wr_d     = row_addr_cmd(2'(row_nxt));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CTRL: begin
                if (wr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_comb begin
        msg_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
    end

    lcd_bus_writer #(
        .STEP_CYC(STEP_CYC),
        .WAIT_CYC(CLEAR_CYC)
    ) u_writer (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (wr_start),
        .cmd_rs    (wr_rs),
        .cmd_data  (wr_d),
        .extra_wait(wr_extra),
        .done      (wr_done),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_d     (lcd_d)
    );

endmodule

// File: tb/tb_lcd_text_engine.sv
// Scoreboard bench for lcd_text_engine: stimulus pushes the expected LCD write
// sequence; monitors pop and compare on every rising E strobe.
module tb_lcd_text_engine;

    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 16;
    localparam int unsigned STEP = 2;
    localparam int unsigned CLR  = 8;
    localparam int unsigned PWR  = 10;
    localparam int unsigned W    = ROWS * COLS * 8;
    localparam int unsigned W4   = 4 * 20 * 8;
    localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic [W-1:0]  msg_in;
    logic          msg_valid, msg_ready, cursor_on, blink_on, busy;
    logic          lcd_en, lcd_rs, lcd_rw;
    logic [7:0]    lcd_d;

    logic [W4-1:0] msg4;
    logic          valid4, ready4, busy4, en4, rs4, rw4, c4, b4;
    logic [7:0]    d4;

    lcd_text_engine #(
        .ROWS(ROWS), .COLS(COLS), .STEP_CYC(STEP), .CLEAR_CYC(CLR),
        .PWRUP_CYC(PWR), .AUTO_REFRESH(1'b0)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .msg_in(msg_in), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
    );

    lcd_text_engine #(
        .ROWS(4), .COLS(20), .STEP_CYC(STEP), .CLEAR_CYC(CLR),
        .PWRUP_CYC(PWR), .AUTO_REFRESH(1'b0)
    ) u_dut4 (
        .clock(clock), .reset_n(reset_n), .msg_in(msg4), .msg_valid(valid4),
        .msg_ready(ready4), .cursor_on(c4), .blink_on(b4), .busy(busy4),
        .lcd_en(en4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_d(d4)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        int unsigned gap;   // required cycles since previous strobe rise, 0 = unconstrained
    } wr_t;

    wr_t         sb[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic        last_c, last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    task automatic push_wr(input logic rs, input logic [7:0] d, input int unsigned gap);
        wr_t e;
        e.rs = rs; e.d = d; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic push_disp();
        push_wr(1'b0, 8'h0C | {6'b0, cursor_on, blink_on}, 0);
        last_c = cursor_on;
        last_b = blink_on;
    endtask

    task automatic push_init();
        push_wr(1'b0, 8'h38, 0);
        push_wr(1'b0, 8'h0C | {6'b0, cursor_on, blink_on}, 3 * STEP);
        push_wr(1'b0, 8'h01, 3 * STEP);
        push_wr(1'b0, 8'h06, 3 * STEP + CLR);
        last_c = cursor_on;
        last_b = blink_on;
    endtask

    task automatic push_frame(input logic [W-1:0] f);
        for (int r = 0; r < int'(ROWS); r++) begin
            push_wr(1'b0, 8'h80 | ROW_BASE[r], (r == 0) ? 0 : 3 * STEP);
            for (int c = 0; c < int'(COLS); c++)
                push_wr(1'b1, f[8 * (r * int'(COLS) + c) +: 8], 3 * STEP);
        end
    endtask

    function automatic logic [W-1:0] text_frame(input string s0, input string s1);
        logic [W-1:0] f = {ROWS * COLS{8'h20}};
        for (int c = 0; c < s0.len() && c < int'(COLS); c++) f[8 * c +: 8] = s0[c];
        for (int c = 0; c < s1.len() && c < int'(COLS); c++) f[8 * (int'(COLS) + c) +: 8] = s1[c];
        return f;
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] f;
        for (int i = 0; i < int'(ROWS * COLS); i++) f[8 * i +: 8] = 8'($urandom_range(32, 126));
        return f;
    endfunction

    // ---------------- monitor (2x16) ----------------
    wr_t         mon_e;
    logic        prev_en = 1'b0;
    int unsigned hi_len = 0, cyc = 0, last_rise = 0;
    logic        cap_rs;
    logic [7:0]  cap_d;

    initial forever begin
        @(negedge clock);
        cyc++;
        if (!reset_n) begin
            prev_en = 1'b0;
            hi_len  = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: actual rs=%0d d=%02h, required no write", lcd_rs, lcd_d);
                end else begin
                    mon_e = sb.pop_front();
                    check("write_rs", 32'(lcd_rs), 32'(mon_e.rs));
                    check("write_data", 32'(lcd_d), 32'(mon_e.d));
                    if (mon_e.gap != 0) check("write_spacing", cyc - last_rise, mon_e.gap);
                end
                last_rise = cyc;
                hi_len    = 1;
                cap_rs    = lcd_rs;
                cap_d     = lcd_d;
            end else if (lcd_en) begin
                hi_len++;
                check("bus_stable_in_strobe", 32'({lcd_rs, lcd_d}), 32'({cap_rs, cap_d}));
            end else if (prev_en) begin
                check("strobe_width", hi_len, STEP);
            end
            prev_en = lcd_en;
        end
    end

    // ---------------- monitor (4x20 row addresses) ----------------
    logic        prev4 = 1'b0;
    int unsigned idx4 = 0;

    initial forever begin
        @(negedge clock);
        if (!reset_n) prev4 = 1'b0;
        else begin
            if (en4 && !prev4 && !rs4 && d4[7]) begin
                if (idx4 < 4) check("row_addr_4x20", 32'(d4), 32'(8'h80 | ROW_BASE[idx4]));
                else begin
                    n_total++;
                    $display("FAIL row_addr_4x20_extra: actual %02h, required none", d4);
                end
                idx4++;
            end
            prev4 = en4;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle();
        int unsigned n = 0, run = 0;
        while (run < 2 && n < 20000) begin
            @(negedge clock);
            n++;
            run = msg_ready ? run + 1 : 0;
        end
        check("return_to_idle", 32'(run >= 2), 1);
    endtask

    task automatic release_reset();
        int unsigned n = 0;
        #1 reset_n = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!lcd_en && n < 200);
        check("pwrup_first_strobe_cycle", n, PWR + STEP);
    endtask

    task automatic send_frame(input logic [W-1:0] f, input bit chk_lat);
        int unsigned n = 0;
        @(negedge clock);
        msg_in    = f;
        msg_valid = 1'b1;
        while (!msg_ready && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check("frame_accepted", 32'(msg_ready), 1);
        push_frame(f);
        @(negedge clock);
        msg_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("not_ready_while_busy", 32'(msg_ready), 0);
        if (chk_lat) begin
            n = 1;
            while (!lcd_en && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("first_strobe_latency", n, STEP + 1);
        end
    endtask

    task automatic set_ctrl(input logic c, input logic b);
        @(negedge clock);
        cursor_on = c;
        blink_on  = b;
        if ({c, b} != {last_c, last_b}) push_disp();
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned n;
        reset_n   = 1'b0;
        msg_in    = '0;
        msg_valid = 1'b0;
        cursor_on = 1'b0;
        blink_on  = 1'b0;
        msg4      = '0;
        valid4    = 1'b0;
        c4        = 1'b0;
        b4        = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_en", 32'(lcd_en), 0);
        check("reset_rs", 32'(lcd_rs), 0);
        check("reset_d", 32'(lcd_d), 0);
        check("reset_rw", 32'(lcd_rw), 0);
        check("reset_ready", 32'(msg_ready), 0);

        push_init();
        release_reset();
        wait_idle();
        check("init_sequence_drained", sb.size(), 0);

        send_frame(text_frame("HELLO", "WORLD"), 1'b1);
        wait_idle();
        check("frame_drained", sb.size(), 0);

        // second frame offered while the first is still being written
        send_frame(rand_frame(), 1'b0);
        send_frame(rand_frame(), 1'b0);
        wait_idle();

        set_ctrl(1'b1, 1'b0);
        set_ctrl(1'b1, 1'b1);
        check("ctrl_drained", sb.size(), 0);

        // frame and control change in the same idle cycle: frame goes first
        @(negedge clock);
        cursor_on = 1'b0;
        msg_in    = rand_frame();
        msg_valid = 1'b1;
        push_frame(msg_in);
        push_disp();
        @(negedge clock);
        msg_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_frame(rand_frame(), 1'b0);
                wait_idle();
            end else begin
                set_ctrl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // reset asserted during a data strobe
        send_frame(rand_frame(), 1'b0);
        n = 0;
        while (!(lcd_en && lcd_rs) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("data_strobe_seen", 32'(lcd_en && lcd_rs), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_en", 32'(lcd_en), 0);
        check("async_reset_rs", 32'(lcd_rs), 0);
        check("async_reset_d", 32'(lcd_d), 0);
        check("async_reset_ready", 32'(msg_ready), 0);
        sb.delete();
        repeat (3) @(negedge clock);
        push_init();
        release_reset();
        wait_idle();
        check("reinit_drained", sb.size(), 0);

        // 4x20 geometry: row address commands
        n = 0;
        while (!ready4 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 80; i++) msg4[8 * i +: 8] = 8'($urandom_range(32, 126));
        valid4 = 1'b1;
        @(negedge clock);
        valid4 = 1'b0;
        n = 0;
        while (!ready4 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("row_addr_4x20_count", idx4, 4);

        repeat (20) @(negedge clock);
        check("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
